// File: rtl/ysyx_25040129_rtc_slave_pkg.sv
`default_nettype none
//============================================================================
// Module      : ysyx_25040129_rtc_slave_pkg
// Description : Shared constants, response codes and FSM encodings for the
//               RTC read-only AXI4-Lite responder.
// Revision    : 1.0 - initial release
//============================================================================
package ysyx_25040129_rtc_slave_pkg;

    // Same window the crossbar decodes against for its RTC port
    localparam logic [31:0] RTC_PORT_ADDR = 32'ha000_0048;
    localparam logic [31:0] RTC_PORT_SIZE = 32'd8;

    localparam logic [1:0]  c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  c_RESP_SLVERR = 2'b10;

    localparam logic [31:0] c_OFF_LO      = 32'd0;
    localparam logic [31:0] c_OFF_HI      = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rtc_state_t;

    // Unsigned offset; addresses below the base wrap to large values
    function automatic logic [31:0] rtc_offset(input logic [31:0] addr,
                                               input logic [31:0] base);
        return addr - base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_25040129_rtc_slave_if.sv
`default_nettype none
//============================================================================
// Module      : ysyx_25040129_rtc_slave_if
// Description : AXI4-Lite read address / read data channels between the
//               crossbar RTC port (master) and the RTC responder (slave).
// Revision    : 1.0 - initial release
//============================================================================
interface ysyx_25040129_rtc_slave_if;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output araddr,
        output arvalid,
        output rready,
        input  arready,
        input  rdata,
        input  rresp,
        input  rvalid
    );

    modport slave (
        input  araddr,
        input  arvalid,
        input  rready,
        output arready,
        output rdata,
        output rresp,
        output rvalid
    );

endinterface
`default_nettype wire

// File: rtl/ysyx_25040129_lfsr8.sv
`default_nettype none
//============================================================================
// Module      : ysyx_25040129_lfsr8
// Description : Seeded 8-bit Fibonacci LFSR, taps 8,6,5,4, with enable.
// Revision    : 1.0 - initial release
//============================================================================
module ysyx_25040129_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_en,
    output logic [7:0]      o_q
);

    logic [7:0] r_q;
    logic       w_fb;

    assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];
    assign o_q  = r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= SEED;
        end else if (i_en) begin
            r_q <= {r_q[6:0], w_fb};
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_25040129_rtc_slave.sv
`default_nettype none
//============================================================================
// Module      : ysyx_25040129_rtc_slave
// Description : AXI4-Lite read-only RTC responder with a free-running 64-bit
//               microsecond counter; the high word is snapshotted on a low
//               word read. Optional random response delay: RTC_DELAY_EN.
// Revision    : 1.0 - initial release
//============================================================================
module ysyx_25040129_rtc_slave
    import ysyx_25040129_rtc_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'ha000_0048,
    parameter int          CLK_DIV   = 1,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    ysyx_25040129_rtc_slave_if.slave    bus
);

    localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic [63:0]        r_mtime;
    logic               w_tick;

    rtc_state_t  r_state, w_state_next;
    logic        r_arready, w_arready_next;
    logic        r_rvalid,  w_rvalid_next;
    logic [31:0] r_rdata,   w_rdata_next;
    logic [1:0]  r_rresp,   w_rresp_next;
    logic [31:0] r_hi_snap, w_hi_snap_next;
    logic [31:0] w_offset;

`ifdef RTC_DELAY_EN
    logic [3:0] w_lfsr_lo;
    logic [3:0] w_lfsr_unused;
    logic [3:0] r_delay, w_delay_next;

    ysyx_25040129_lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .i_en (1'b1),
        .o_q  ({w_lfsr_unused, w_lfsr_lo})
    );
`endif

    // Counter runs regardless of bus state; mtime is written every cycle
    assign w_tick = (r_div_cnt == c_DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_mtime   <= 64'd0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            r_mtime   <= w_tick ? r_mtime + 64'd1 : r_mtime;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_arready_next = r_arready;
        w_rvalid_next  = r_rvalid;
        w_rdata_next   = r_rdata;
        w_rresp_next   = r_rresp;
        w_hi_snap_next = r_hi_snap;
`ifdef RTC_DELAY_EN
        w_delay_next   = r_delay;
`endif
        w_offset       = rtc_offset(bus.araddr, BASE_ADDR);

        case (r_state)
            ST_IDLE: begin
                w_arready_next = 1'b1;
                if (bus.arvalid && r_arready) begin
                    w_arready_next = 1'b0;
                    if (w_offset == c_OFF_LO) begin
                        w_rdata_next   = r_mtime[31:0];
                        w_hi_snap_next = r_mtime[63:32];
                        w_rresp_next   = c_RESP_OKAY;
                    end else if (w_offset == c_OFF_HI) begin
                        w_rdata_next   = r_hi_snap;
                        w_rresp_next   = c_RESP_OKAY;
                    end else begin
                        w_rdata_next   = 32'd0;
                        w_rresp_next   = c_RESP_SLVERR;
                    end
`ifdef RTC_DELAY_EN
                    // Latency is lfsr[3:0]+1 cycles: zero skips WAIT entirely
                    w_delay_next = w_lfsr_lo;
                    if (w_lfsr_lo == 4'd0) begin
                        w_state_next  = ST_RESP;
                        w_rvalid_next = 1'b1;
                    end else begin
                        w_state_next  = ST_WAIT;
                    end
`else
                    w_state_next  = ST_RESP;
                    w_rvalid_next = 1'b1;
`endif
                end
            end
`ifdef RTC_DELAY_EN
            ST_WAIT: begin
                w_delay_next = r_delay - 4'd1;
                if (r_delay == 4'd1) begin
                    w_state_next  = ST_RESP;
                    w_rvalid_next = 1'b1;
                end
            end
`endif
            ST_RESP: begin
                w_rvalid_next = 1'b1;
                if (bus.rready) begin
                    w_rvalid_next  = 1'b0;
                    w_arready_next = 1'b1;
                    w_state_next   = ST_IDLE;
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_arready_next = 1'b0;
                w_rvalid_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
            r_rresp   <= c_RESP_OKAY;
            r_hi_snap <= 32'd0;
`ifdef RTC_DELAY_EN
            r_delay   <= 4'd0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_arready <= w_arready_next;
            r_rvalid  <= w_rvalid_next;
            r_rdata   <= w_rdata_next;
            r_rresp   <= w_rresp_next;
            r_hi_snap <= w_hi_snap_next;
`ifdef RTC_DELAY_EN
            r_delay   <= w_delay_next;
`endif
        end
    end

    assign bus.arready = r_arready;
    assign bus.rvalid  = r_rvalid;
    assign bus.rdata   = r_rdata;
    assign bus.rresp   = r_rresp;

endmodule
`default_nettype wire

// File: doc/ysyx_25040129_rtc_slave.md
Name: ysyx_25040129_rtc_slave

Overview:
AXI4-Lite read-only responder for the real-time clock. It sits behind the crossbar's RTC port and answers the crossbar's `rtc_ar*` / `rtc_r*` channels. It holds a free-running 64-bit microsecond counter, read as two 32-bit words. The high word is snapshotted when the low word is read, so a 64-bit read is consistent.

Parameters:
- `BASE_ADDR`, `32'ha000_0048`: byte address of counter low word; the high word is at `BASE_ADDR+4`.
- `CLK_DIV`, `1`: clk cycles per counter increment; legal range ≥1.
- `LFSR_SEED`, `8'hA5`: nonzero seed for the delay LFSR (used only under `RTC_DELAY_EN`).

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset: synchronous, active-high
- `araddr`  in  32  read address from crossbar
- `arvalid`  in  1  read address valid
- `arready`  out  1  read address ready
- `rdata`  out  32  read data
- `rresp`  out  2  response: `2'b00` OKAY, `2'b10` SLVERR
- `rvalid`  out  1  read data valid
- `rready`  in  1  read data ready

Behaviour:
- **Reset values:** `arready=0`, `rvalid=0`, `rdata=0`, `rresp=00`, `mtime=0`, `hi_snap=0`, `div_cnt=0`, state=IDLE. `arready` rises in the first cycle after `rst` deasserts.
- **Counter:**
  - `div_cnt` counts 0..`CLK_DIV`-1; when it equals `CLK_DIV`-1 it wraps to 0 and `mtime` increments by 1.
  - `mtime` wraps `64'hFFFF_FFFF_FFFF_FFFF` → 0.
  - The counter runs in every state, independent of bus traffic.
- **State machine:** states IDLE and RESP, plus WAIT under `RTC_DELAY_EN`.
  - **IDLE:**
    - `arready=1`.
    - On `arvalid&&arready`: decode `araddr`, register `rdata`/`rresp`, deassert `arready`, go to RESP.
    - With `RTC_DELAY_EN`, go to WAIT instead.
  - **RESP:**
    - `rvalid=1`; `rdata`/`rresp` held stable until `rvalid&&rready`.
    - On handshake: `rvalid←0`, `arready←1`, go to IDLE.
    - Next accept is possible the cycle after the handshake.
- **Latency:** address handshake in cycle N → `rvalid` high in cycle N+1 (no delay feature).
- **Decode:** `off = araddr - BASE_ADDR`, 32-bit unsigned.
  - `off==0`: `rdata = mtime[31:0]` sampled in the accept cycle (pre-increment if a tick coincides); `hi_snap ← mtime[63:32]` from the same sample; `rresp` OKAY.
  - `off==4`: `rdata = hi_snap`; `rresp` OKAY. `hi_snap` is not modified.
  - Any other `off` (out of window, `araddr[1:0]!=0`, or `araddr` < `BASE_ADDR` which wraps to large): `rdata=0`, `rresp=SLVERR`, `hi_snap` unchanged.
- **`arvalid` while busy:** ignored (`arready=0`); the master must hold it, per AXI.
- **`rready` low:** no timeout; `rvalid`/`rdata` held indefinitely.
- **Reset mid-transaction:** outstanding response dropped; all outputs return to reset values the next cycle; `mtime` cleared.

Optional Feature:
- **Macro:** `RTC_DELAY_EN`.
- **With the macro:**
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seeded `LFSR_SEED`) advances every cycle.
  - On accept, `delay ← lfsr[3:0]`; FSM enters WAIT, decrements `delay` each cycle, and enters RESP when `delay==0`.
  - Resulting latency is 1..16 cycles.
  - Data is still sampled in the accept cycle.
- **Without the macro:** no LFSR, no WAIT state, fixed 1-cycle latency.

Decomposition:
- **Shared package/header:**
  - `RTC_PORT_ADDR`, `RTC_PORT_SIZE (8)` (same macros the crossbar decodes against).
  - Response codes `OKAY=2'b00`, `SLVERR=2'b10`.
  - State encodings IDLE/WAIT/RESP.
- **Sub-module:** `ysyx_25040129_lfsr8` (seeded 8-bit LFSR, enable input), instantiated only under `RTC_DELAY_EN`. The counter/divider stays inline.

Test Plan:
- **Reset, then simple read:** `CLK_DIV=1`, release `rst`, wait 10 cycles, read `0xa000_0048` with `rready=1` → `arready=1` before request; `rvalid` exactly 1 cycle after accept; `rdata=10`±0 per accept-cycle sample; `rresp=00`.
- **Consistent 64-bit read across carry:** force `mtime=64'h0000_0000_FFFF_FFFF` (backdoor), read low then high 5 cycles later → low `32'hFFFF_FFFF`, high `0` (snapshot), not 1.
- **Back-pressure:** hold `rready=0` for 7 cycles after `rvalid` → `rdata`/`rresp` stable all 7 cycles, `arready=0`; after handshake, `arready=1` next cycle.
- **Error decode:** read `0xa000_0050`, `0xa000_0049`, `0xa000_0044` → `rresp=2'b10`, `rdata=0`; a following read of `0xa000_004C` returns the prior `hi_snap` unchanged.
- **Divider and wrap:** `CLK_DIV=4`, run 40 cycles → low word 10; preload `mtime=64'hFFFF_FFFF_FFFF_FFFF`, one tick → low 0, high 0 after re-read.
- **Mid-response reset (`RTC_DELAY_EN` defined):** issue read, assert `rst` during WAIT/RESP → `rvalid=0`, `arready=0` the next cycle. After release, 20 back-to-back reads all show latency in 1..16 with monotonic low words.
